// File: rtl/alu_issue.sv
// Single-issue R-type sequencer: IDLE accepts, EXEC drives the ALU for one cycle, WB holds the result.
// Optional feature macro ALU_ISSUE_TRAP_EN: unsupported instructions are trapped and reported via illegal.
module alu_issue #(
  parameter int RF_DEPTH = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic [4:0]        res_rd,
  output logic              illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] rf_q [0:RF_DEPTH-1];
  logic [3:0]        alu_ctl_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zero_q;
  logic [4:0]        res_rd_q;
  logic [3:0]        dec_ctl_d;

  logic [4:0] rs, rt, rd;
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    dec_ctl_d = 4'd15;
    if (instr[31:26] == 6'd0) begin
      case (instr[5:0])
        6'd32:   dec_ctl_d = 4'd2;
        6'd34:   dec_ctl_d = 4'd6;
        6'd36:   dec_ctl_d = 4'd0;
        6'd37:   dec_ctl_d = 4'd1;
        6'd39:   dec_ctl_d = 4'd12;
        6'd42:   dec_ctl_d = 4'd7;
        default: dec_ctl_d = 4'd15;
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] addr);
    return (addr == 5'd0) ? '0 : rf_q[addr];
  endfunction

`ifdef ALU_ISSUE_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alu_ctl_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rd_q       <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_rd_q   <= '0;
`ifdef ALU_ISSUE_TRAP_EN
      illegal_q  <= 1'b0;
`endif
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
`ifdef ALU_ISSUE_TRAP_EN
      illegal_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          // Operands below read the pre-write array, so a same-cycle preload is not forwarded.
          if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
          if (instr_valid) begin
`ifdef ALU_ISSUE_TRAP_EN
            if (dec_ctl_d == 4'd15) illegal_q <= 1'b1;
            else
`endif
            begin
              alu_a_q   <= rf_read(rs);
              alu_b_q   <= rf_read(rt);
              alu_ctl_q <= dec_ctl_d;
              rd_q      <= rd;
              state_q   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          res_data_q <= alu_out;
          res_zero_q <= alu_zero;
          res_rd_q   <= rd_q;
          if (rd_q != 5'd0) rf_q[rd_q] <= alu_out;
          state_q    <= S_WB;
        end
        S_WB: begin
          if (res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_WB);
  assign alu_ctl     = alu_ctl_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_rd      = res_rd_q;

endmodule
